// File: rtl/spi_master_single.sv
// spi_master_single
//   Single-word SPI master. One tx_valid/tx_ready handshake launches one
//   complete cs_n frame (MSB first) in any CPOL/CPHA mode with 2..32-bit words.
//   After every frame, cs_n stays high for a guaranteed idle gap. This lets
//   the peer slave resynchronise into its own clock domain.
// Ports
//   sclk, sys_rst_n        engine clock (rising edge), async active-low reset
//   cfg_cpol/cpha/bit_len  frame configuration, latched on accept
//                          (bit_len 0 -> 8 bits, n -> n+1 bits)
//   tx_valid/ready/data    word handshake; tx_data right-aligned
//   rx_data/rx_valid       received word (right-aligned, upper bits zero) + 1-cycle strobe
//   busy                   frame in progress
//   spi_sclk_o/cs_n_o/mosi_o, spi_miso_i   registered SPI bus
module spi_master_single #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic        sclk,
  input  logic        sys_rst_n,
  input  logic        cfg_cpol,
  input  logic        cfg_cpha,
  input  logic [4:0]  cfg_bit_len,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        spi_sclk_o,
  output logic        spi_cs_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  if (CLK_DIV < 1) begin : g_chk_div
    $error("spi_master_single: CLK_DIV must be >= 1");
  end
  if (CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1) begin : g_chk_cs
    $error("spi_master_single: CS_SETUP/CS_HOLD/CS_IDLE must be >= 1");
  end

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;       // cycle counter for SETUP/HOLD/GAP
  logic [15:0] div_q, div_d;       // half-period divider in SHIFT
  logic [5:0]  bit_q;              // completed bits (counts trailing edges)
  logic        lead_q;             // 1: leading edge done, trailing edge next
  logic        cpol_q, cpha_q;
  logic [5:0]  nbits_q;
  logic [31:0] tx_sr_q, rx_sr_q, rx_data_q;
  logic        sclk_q, cs_n_q, mosi_q, rx_valid_q;

  logic [5:0]  nbits_in;
  logic [31:0] tx_align;
  logic        accept, edge_ev, last_edge, phase_end;

  assign nbits_in  = (cfg_bit_len == 5'd0) ? 6'd8 : {1'b0, cfg_bit_len} + 6'd1;
  // Left-align the word so the shift register always drives bit 31.
  assign tx_align  = tx_data << (6'd32 - nbits_in);
  assign accept    = tx_valid & tx_ready;
  assign edge_ev   = (state_q == ST_SHIFT) && (div_q == DIV_LAST);
  assign last_edge = edge_ev && lead_q && ((bit_q + 6'd1) == nbits_q);

  always_comb begin
    phase_end = 1'b0;
    case (state_q)
      ST_SETUP: phase_end = (cnt_q == SETUP_LAST);
      ST_HOLD:  phase_end = (cnt_q == HOLD_LAST);
      ST_GAP:   phase_end = (cnt_q == IDLE_LAST);
      default:  phase_end = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge sclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_SETUP;
      ST_SETUP: if (phase_end) state_d = ST_SHIFT;
      ST_SHIFT: if (last_edge) state_d = ST_HOLD;
      ST_HOLD:  if (phase_end) state_d = ST_GAP;
      ST_GAP:   if (phase_end) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == ST_IDLE || state_q == ST_SHIFT)
            ? 16'd0 : cnt_q + 16'd1;
    div_d = (state_q == ST_SHIFT && !edge_ev) ? div_q + 16'd1 : 16'd0;
  end

  // Output logic
  always_comb begin
    tx_ready = (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
  end

  // SPI datapath
  always_ff @(posedge sclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      nbits_q    <= 6'd8;
      bit_q      <= '0;
      lead_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sclk_q <= cfg_cpol;
          if (accept) begin
            cpol_q  <= cfg_cpol;
            cpha_q  <= cfg_cpha;
            nbits_q <= nbits_in;
            cs_n_q  <= 1'b0;
            rx_sr_q <= '0;
            bit_q   <= '0;
            lead_q  <= 1'b0;
            // CPHA=0 needs the first bit on the wire before the first edge.
            if (!cfg_cpha) begin
              mosi_q  <= tx_align[31];
              tx_sr_q <= tx_align << 1;
            end else begin
              tx_sr_q <= tx_align;
            end
          end
        end
        ST_SHIFT: begin
          if (edge_ev) begin
            sclk_q <= ~sclk_q;
            if (!lead_q) begin
              lead_q <= 1'b1;
              if (!cpha_q) begin
                rx_sr_q <= {rx_sr_q[30:0], spi_miso_i};
              end else begin
                mosi_q  <= tx_sr_q[31];
                tx_sr_q <= tx_sr_q << 1;
              end
            end else begin
              lead_q <= 1'b0;
              bit_q  <= bit_q + 6'd1;
              if (cpha_q) begin
                rx_sr_q <= {rx_sr_q[30:0], spi_miso_i};
              end else if (!last_edge) begin
                mosi_q  <= tx_sr_q[31];
                tx_sr_q <= tx_sr_q << 1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (phase_end) begin
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_data_q  <= rx_sr_q & ~(32'hFFFF_FFFF << nbits_q);
            rx_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign spi_sclk_o = sclk_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_mosi_o = mosi_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;

endmodule
